// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with a one-byte holding register,
// polled by the core through a valid/read handshake, plus sticky
// framing-error and overrun flags.
module uart_rx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_Rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, rx_s_q, rx_prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, frame_err_q, overrun_q;
    logic          start_det, load_evt, ferr_evt;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= UART_Rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_det = rx_prev_q & ~rx_s_q;

    // Frame FSM next-state: bit timing, bit index and shift register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        load_evt = 1'b0;
        ferr_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    load_evt = rx_s_q;
                    ferr_evt = ~rx_s_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Frame FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Holding register and sticky flags; a flag set beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (err_clr) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            if (ferr_evt) frame_err_q <= 1'b1;
            if (load_evt) begin
                if (!rx_valid_q || rd_en) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rd_en) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at 16 clocks per bit. Frames are driven
// bit-by-bit from a cycle-accurate task; expected bytes go into a queue and
// are popped when the holding register is checked.
module tb_uart_rx_mmio;

    localparam int unsigned CPB = 16;
    // Cycle index (within a frame driven from the task) whose following edge
    // samples the stop bit: 3 edges to enter START, 8 to the start sample,
    // then 9 bit periods of 16.
    localparam int LOAD_I = 154;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       UART_Rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun;

    int ncmp = 0;
    int nfail = 0;
    logic [7:0] exp_q[$];

    uart_rx_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .UART_Rx(UART_Rx), .rd_en(rd_en),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame for ncyc cycles, optionally pulsing rd_en/err_clr
    // so that they are sampled on the stop-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ncyc,
                              input logic rd_on_load, input logic clr_on_load);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < ncyc; i++) begin
            UART_Rx = bits[i / CPB];
            rd_en   = rd_on_load && (i == LOAD_I);
            err_clr = clr_on_load && (i == LOAD_I);
            if (i == 100) check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
            if (i == LOAD_I) check("busy_before_stop", {31'd0, rx_busy}, 32'd1);
            if (i == LOAD_I + 1) check("busy_after_stop", {31'd0, rx_busy}, 32'd0);
            tick(1);
        end
        UART_Rx = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        ncmp++;
        assert (exp_q.size() != 0) else begin
            nfail++;
            $error("FAIL %s: observed empty scoreboard expected pending byte", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, {24'd0, rx_data}, {24'd0, e});
        end
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        // 1: reset state, then reset in the middle of a frame
        tick(3);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_flags", {28'd0, rx_valid, rx_busy, frame_err, overrun}, 32'd0);
        rst = 1'b0;
        tick(2);
        send_frame(8'h00, 1'b1, 40, 1'b0, 1'b0);
        check("busy_before_rst", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_flags", {28'd0, rx_valid, rx_busy, frame_err, overrun}, 32'd0);
        tick(200);
        check("post_rst_quiet", {28'd0, rx_valid, rx_busy, frame_err, overrun}, 32'd0);

        // 2: normal frame and read
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 160, 1'b0, 1'b0);
        check_rx("a5");
        pulse_rd();
        check("a5_valid_clr", {31'd0, rx_valid}, 32'd0);
        check("a5_data_hold", {24'd0, rx_data}, 32'hA5);

        // 3: false start
        UART_Rx = 1'b0;
        tick(4);
        UART_Rx = 1'b1;
        tick(2);
        check("fs_busy", {31'd0, rx_busy}, 32'd1);
        tick(20);
        check("fs_idle", {28'd0, rx_valid, rx_busy, frame_err, overrun}, 32'd0);

        // 4: framing error, clear, then a good frame
        send_frame(8'h3C, 1'b0, 160, 1'b0, 1'b0);
        check("fe_set", {31'd0, frame_err}, 32'd1);
        check("fe_no_valid", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        check("fe_clr", {31'd0, frame_err}, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 160, 1'b0, 1'b0);
        check_rx("5a");
        pulse_rd();

        // 5: overrun, then load with read on the same edge
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 160, 1'b0, 1'b0);
        check("ov_clear_first", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 1'b1, 160, 1'b0, 1'b0);
        check_rx("ov_keep11");
        check("ov_set", {31'd0, overrun}, 32'd1);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 160, 1'b1, 1'b0);
        check_rx("rd_on_load33");
        check("ov_sticky", {31'd0, overrun}, 32'd1);
        pulse_rd();
        check("rd33_clr", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        check("ov_clr", {31'd0, overrun}, 32'd0);

        // 6: err_clr on the framing-error edge - the set wins
        send_frame(8'h77, 1'b0, 160, 1'b0, 1'b1);
        check("fe_set_wins", {31'd0, frame_err}, 32'd1);
        check("fe_set_wins_valid", {31'd0, rx_valid}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
